// File: rtl/minisys_pkg.sv
// Shared encodings and state type for the MiniSys-1A EXE-stage multiply/divide unit.
package minisys_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DIV_RUN,
    S_DONE
  } md_state_e;

endpackage

// File: rtl/minisys_div_iter.sv
// Restoring radix-2 divider core on unsigned magnitudes: one quotient bit per step.
// quo_next/rem_next expose the post-step values so the caller can capture the final step directly.
module minisys_div_iter
  import minisys_pkg::*;
#(
  parameter int DW = DIV_STEPS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          last,
  output logic [DW-1:0] quo_next,
  output logic [DW-1:0] rem_next
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] quo, rem, dvs;
  logic [CW-1:0] cnt;
  logic [DW:0]   part, trial;

  // rem < dvs holds throughout, so the trial difference never needs more than DW bits
  // when it is non-negative; trial[DW] is therefore a clean borrow flag.
  always_comb begin
    part     = {rem, quo[DW-1]};
    trial    = part - {1'b0, dvs};
    quo_next = {quo[DW-2:0], ~trial[DW]};
    rem_next = trial[DW] ? part[DW-1:0] : trial[DW-1:0];
  end

  assign last = (cnt == CW'(DW-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= '0;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/minisys_exe_md.sv
// EXE-stage multiply/divide unit: MULT/MULTU with fixed latency, DIV/DIVU iterative,
// HI/LO result strobe plus busy/over/keep signals for decode-stage stalling and forwarding.
module minisys_exe_md
  import minisys_pkg::*;
#(
  parameter int DW       = 32,
  parameter int MULT_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          md_start,
  input  logic [1:0]    alu_md,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic          multbusy,
  output logic          multover,
  output logic          divbusy,
  output logic          divover,
  output logic          keepmd,
  output logic          mdcs,
  output logic [DW-1:0] mdhidata,
  output logic [DW-1:0] mdlodata,
  output logic          div0
);

  localparam int MCW     = $clog2(MULT_LAT + 1);
  localparam int MC_INIT = (MULT_LAT >= 2) ? MULT_LAT - 2 : 0;

  md_state_e state, state_nxt;

  logic            accept, is_sgn, a_neg, b_neg;
  logic [DW-1:0]   mag_a, mag_b;
  logic [2*DW-1:0] ext_a, ext_b, prod_comb, prod;
  logic            op_div, neg_q, neg_r, b_zero;
  logic [DW-1:0]   a_q;
  logic [MCW-1:0]  mcnt;
  logic            div_last;
  logic [DW-1:0]   quo_next, rem_next, quo_fix, rem_fix;

  assign accept = md_start && (state == S_IDLE || state == S_DONE);
  assign is_sgn = ~alu_md[0];
  assign a_neg  = is_sgn & opa[DW-1];
  assign b_neg  = is_sgn & opb[DW-1];
  assign mag_a  = a_neg ? -opa : opa;
  assign mag_b  = b_neg ? -opb : opb;

  // Sign-extend to 2*DW so one multiplier serves both signed and unsigned forms.
  assign ext_a     = {{DW{a_neg}}, opa};
  assign ext_b     = {{DW{b_neg}}, opb};
  assign prod_comb = ext_a * ext_b;

  assign quo_fix = neg_q ? -quo_next : quo_next;
  assign rem_fix = neg_r ? -rem_next : rem_next;

  minisys_div_iter #(.DW(DW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept & alu_md[1]),
    .step     (state == S_DIV_RUN),
    .dividend (mag_a),
    .divisor  (mag_b),
    .last     (div_last),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (!md_start)      state_nxt = S_IDLE;
        else if (alu_md[1]) state_nxt = S_DIV_RUN;
        else if (MULT_LAT == 1) state_nxt = S_DONE;
        else                state_nxt = S_MUL_RUN;
      end
      S_MUL_RUN: if (mcnt == '0) state_nxt = S_DONE;
      S_DIV_RUN: if (div_last)   state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_div   <= 1'b0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      prod     <= '0;
      mcnt     <= '0;
      mdhidata <= '0;
      mdlodata <= '0;
    end else begin
      if (accept) begin
        op_div <= alu_md[1];
        a_q    <= opa;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        b_zero <= (opb == '0);
        prod   <= prod_comb;
        mcnt   <= MCW'(MC_INIT);
        if (!alu_md[1] && MULT_LAT == 1) {mdhidata, mdlodata} <= prod_comb;
      end
      if (state == S_MUL_RUN) begin
        if (mcnt == '0) {mdhidata, mdlodata} <= prod;
        else            mcnt <= mcnt - 1'b1;
      end
      if (state == S_DIV_RUN && div_last) begin
        mdhidata <= b_zero ? a_q : rem_fix;
        mdlodata <= b_zero ? '1  : quo_fix;
      end
    end
  end

  assign keepmd   = (state != S_IDLE);
  assign mdcs     = (state == S_DONE);
  assign multover = mdcs & ~op_div;
  assign divover  = mdcs & op_div;
  assign multbusy = (state == S_MUL_RUN) | multover;
  assign divbusy  = (state == S_DIV_RUN) | divover;
  assign div0     = divover & b_zero;

endmodule

// File: tb/tb_minisys_exe_md.sv
// Self-checking bench for minisys_exe_md: directed and randomized MULT/DIV against a 64-bit arithmetic model.
module tb_minisys_exe_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [1:0]  alu_md;
  logic [31:0] opa, opb;
  logic        multbusy, multover, divbusy, divover, keepmd, mdcs, div0;
  logic [31:0] mdhidata, mdlodata;

  int checks = 0;
  int errors = 0;

  minisys_exe_md #(.DW(32), .MULT_LAT(4)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .alu_md(alu_md), .opa(opa), .opb(opb),
    .multbusy(multbusy), .multover(multover), .divbusy(divbusy), .divover(divover),
    .keepmd(keepmd), .mdcs(mdcs), .mdhidata(mdhidata), .mdlodata(mdlodata), .div0(div0)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like MIPS.
  task automatic model(input logic [1:0] op, input logic [31:0] a, b,
                       output logic [31:0] hi, lo, output logic d0);
    longint    sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d0 = 1'b0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; d0 = 1'b1; end
        else begin p = 64'(sa / sb); lo = p[31:0]; p = 64'(sa % sb); hi = p[31:0]; end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; d0 = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // Drives one op from a negedge and records what happens up to the mdcs cycle.
  // Returns at the negedge of the mdcs cycle; lat=0 means mdcs never came.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, b, input int noise_lim,
                       output int lat, output logic [31:0] hi, lo,
                       output logic d0, mov, dov, output int mb, db, kp);
    md_start = 1'b1; alu_md = op; opa = a; opb = b;
    @(posedge clk);
    @(negedge clk);
    md_start = 1'b0; alu_md = 2'($urandom); opa = $urandom; opb = $urandom;
    lat = 0; mb = 0; db = 0; kp = 0; hi = 'x; lo = 'x; d0 = 1'bx; mov = 1'bx; dov = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      mb += int'(multbusy); db += int'(divbusy); kp += int'(keepmd);
      if (mdcs) begin
        lat = c; hi = mdhidata; lo = mdlodata; d0 = div0; mov = multover; dov = divover;
        md_start = 1'b0;
        break;
      end
      md_start = (c < noise_lim) ? 1'($urandom) : 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; md_start = 1'b0; alu_md = 2'b00; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({multbusy, multover, divbusy, divover, keepmd, mdcs, div0, mdhidata, mdlodata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b/%b/%b/%b/%b/%b hi=%h lo=%h required all 0",
               multbusy, multover, divbusy, divover, keepmd, mdcs, div0, mdhidata, mdlodata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a, b,
                           input int noise_lim);
    int lat, mb, db, kp, elat;
    logic [31:0] hi, lo, ehi, elo;
    logic d0, mov, dov, ed0;
    model(op, a, b, ehi, elo, ed0);
    elat = op[1] ? 33 : 4;
    issue(op, a, b, noise_lim, lat, hi, lo, d0, mov, dov, mb, db, kp);
    checks++;
    if (lat != elat) begin
      errors++; $display("FAIL %s_latency a=%h b=%h got %0d required %0d", name, a, b, lat, elat);
    end
    checks++;
    if (hi !== ehi || lo !== elo) begin
      errors++; $display("FAIL %s_result op=%0d a=%h b=%h got hi=%h lo=%h required hi=%h lo=%h",
                         name, op, a, b, hi, lo, ehi, elo);
    end
    checks++;
    if (mov !== !op[1] || dov !== op[1] || d0 !== ed0) begin
      errors++; $display("FAIL %s_over got mov=%b dov=%b div0=%b required %b %b %b",
                         name, mov, dov, d0, !op[1], op[1], ed0);
    end
    checks++;
    if (mb != (op[1] ? 0 : 4) || db != (op[1] ? 33 : 0) || kp != elat) begin
      errors++; $display("FAIL %s_busy got mb=%0d db=%0d keep=%0d required %0d %0d %0d",
                         name, mb, db, kp, op[1] ? 0 : 4, op[1] ? 33 : 0, elat);
    end
    @(negedge clk);
    checks++;
    if (mdcs !== 1'b0 || keepmd !== 1'b0 || mdhidata !== ehi || mdlodata !== elo) begin
      errors++; $display("FAIL %s_after got mdcs=%b keep=%b hi=%h lo=%h required 0 0 %h %h",
                         name, mdcs, keepmd, mdhidata, mdlodata, ehi, elo);
    end
  endtask

  task automatic test_mult();
    run_check("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    run_check("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 6; i++)
      run_check("mult_rand", 2'($urandom_range(0, 1)), $urandom, $urandom, 3);
  endtask

  task automatic test_div();
    run_check("div_neg7by2",  2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_check("divu_100by7",  2'b11, 32'd100, 32'd7, 0);
    run_check("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_check("divu_by0",     2'b11, 32'd5, 32'd0, 0);
    run_check("div_by0_neg",  2'b10, 32'hFFFF_FF00, 32'd0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] b;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (b[31] && i == 5) b = 32'hFFFF_FFF3;
      run_check("div_rand", 2'($urandom_range(2, 3)), $urandom, b, 30);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    md_start = 1'b1; alu_md = 2'b10; opa = 32'd100; opb = 32'd3;
    @(posedge clk);
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({multbusy, multover, divbusy, divover, keepmd, mdcs, div0, mdhidata, mdlodata} !== '0) begin
      errors++; $display("FAIL midreset_outputs got keep=%b dbusy=%b hi=%h lo=%h required all 0",
                         keepmd, divbusy, mdhidata, mdlodata);
    end
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(mdcs | keepmd);
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_no_mdcs got %0d active cycles required 0", seen);
    end
    run_check("mult_after_rst", 2'b00, 32'd7, 32'hFFFF_FFFE, 0);
  endtask

  task automatic test_back_to_back();
    int lat, mb, db, kp;
    logic [31:0] hi, lo;
    logic d0, mov, dov;
    issue(2'b00, 32'd3, 32'd4, 0, lat, hi, lo, d0, mov, dov, mb, db, kp);
    checks++;
    if (lat != 4 || hi !== 32'd0 || lo !== 32'd12) begin
      errors++; $display("FAIL b2b_first got lat=%0d hi=%h lo=%h required 4 0 0000000c", lat, hi, lo);
    end
    // Start held in the DONE cycle: accepted with no IDLE gap, keepmd never drops.
    issue(2'b11, 32'd9, 32'd2, 30, lat, hi, lo, d0, mov, dov, mb, db, kp);
    checks++;
    if (lat != 33 || hi !== 32'd1 || lo !== 32'd4 || kp != 33 || dov !== 1'b1) begin
      errors++; $display("FAIL b2b_second got lat=%0d hi=%h lo=%h keep=%0d dov=%b required 33 1 4 33 1",
                         lat, hi, lo, kp, dov);
    end
    @(negedge clk);
    checks++;
    if (keepmd !== 1'b0 || mdcs !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got keep=%b mdcs=%b required 0 0", keepmd, mdcs);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
